// File: rtl/node_pkg.sv
// Shared encodings for the sensor-node scheduler: controller instruction codes,
// scheduler state encoding and common widths.
package node_pkg;

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned INST_W  = 2;

  // Instruction codes understood by the controller.
  typedef enum logic [INST_W-1:0] {
    INST_NONE        = 2'b00,
    INST_READ_SENSOR = 2'b01,
    INST_READ_RADIO  = 2'b10,
    INST_WRITE_RADIO = 2'b11
  } inst_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_DONE = 2'b10
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sample_timer.sv
// Free-running sample period counter; tick_c_o is high in the last cycle of
// each period, i.e. on the cycle whose edge wraps the counter back to 0.
module sample_timer
  import node_pkg::*;
#(
  parameter int unsigned PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic tick_c_o
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;
  logic               wrap_c;

  assign wrap_c = run_i && (cnt_q == TIMER_W'(PERIOD - 1));

  // Held at zero while not running, so a restart always sees a full period.
  always_comb begin
    cnt_d = cnt_q + TIMER_W'(1);
    if (!run_i || wrap_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c_o = wrap_c;

endmodule

// File: rtl/node_scheduler.sv
// Sensor-node scheduler: arbitrates radio receive, radio transmit and sensor
// sampling onto a single controller instruction port.
module node_scheduler
  import node_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD  = 1000,
  parameter int unsigned BATCH_SIZE     = 8,
  parameter int unsigned ACCEPT_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              ctrl_busy,
  input  logic              radio_busy,
  input  logic              rx_pending,
  output logic              ctrl_enable,
  output logic [INST_W-1:0] ctrl_inst,
  output logic [CNT_W-1:0]  sample_count,
  output logic              overrun,
  output logic              timeout_err,
  output logic              sched_busy
);

  state_e             state_q, state_d;
  inst_e              op_q, op_d, sel_op_c;
  inst_e              inst_q;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               armed_q;
  logic               tick_c, accept_c, timeout_c, clr_pend_c;
  logic               ctrl_enable_q, overrun_q, timeout_q, busy_q;

  sample_timer #(
    .PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run_i   (run),
    .tick_c_o(tick_c)
  );

  // Fixed-priority selection: receive, then transmit, then sample.
  always_comb begin
    sel_op_c = INST_NONE;
    if (rx_pending && !radio_busy) begin
      sel_op_c = INST_READ_RADIO;
    end else if ((cnt_q >= CNT_W'(BATCH_SIZE)) && !radio_busy) begin
      sel_op_c = INST_WRITE_RADIO;
    end else if (pend_q) begin
      sel_op_c = INST_READ_SENSOR;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    accept_c  = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // armed_q keeps the first edge after reset release decision-free.
        if (run && armed_q && (sel_op_c != INST_NONE)) begin
          state_d = ST_ISSUE;
          op_d    = sel_op_c;
          acc_d   = '0;
        end
      end
      ST_ISSUE: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (ctrl_busy) begin
          accept_c = 1'b1;
          state_d  = ST_WAIT_DONE;
          if (op_q == INST_READ_SENSOR) begin
            cnt_d = sat_inc(cnt_q);
          end else if (op_q == INST_WRITE_RADIO) begin
            cnt_d = '0;
          end
        end else if (acc_q == CNT_W'(ACCEPT_TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          acc_d = acc_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!ctrl_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A tick landing on the same edge that retires a sample re-arms the request.
  assign clr_pend_c = (accept_c || timeout_c) && (op_q == INST_READ_SENSOR);
  assign pend_d     = tick_c || (pend_q && !clr_pend_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= INST_NONE;
      inst_q        <= INST_NONE;
      acc_q         <= '0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      armed_q       <= 1'b0;
      ctrl_enable_q <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      inst_q        <= (state_d == ST_ISSUE) ? op_d : INST_NONE;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      armed_q       <= 1'b1;
      ctrl_enable_q <= run || (state_d == ST_WAIT_DONE);
      overrun_q     <= tick_c && pend_q && !clr_pend_c;
      timeout_q     <= timeout_c;
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign ctrl_enable  = ctrl_enable_q;
  assign ctrl_inst    = inst_q;
  assign sample_count = cnt_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_q;
  assign sched_busy   = busy_q;

endmodule

// File: tb/tb_node_scheduler.sv
// Directed bench: instance A (period 10, batch 2, timeout 16) with a responsive
// controller model, instance B (timeout 4) whose controller never answers.
module tb_node_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, run_a, rx_a;
  logic       busy_a = 1'b0;
  logic       rbusy_a = 1'b0;
  logic       en_a, ovr_a, to_a, sb_a;
  logic [1:0] inst_a;
  logic [7:0] cnt_a;

  logic       rst_b, run_b;
  logic       busy_b = 1'b0;
  logic       rbusy_b = 1'b0;
  logic       rx_b = 1'b0;
  logic       en_b, ovr_b, to_b, sb_b;
  logic [1:0] inst_b;
  logic [7:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  node_scheduler #(
    .SAMPLE_PERIOD(10), .BATCH_SIZE(2), .ACCEPT_TIMEOUT(16)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .run(run_a), .ctrl_busy(busy_a),
    .radio_busy(rbusy_a), .rx_pending(rx_a), .ctrl_enable(en_a),
    .ctrl_inst(inst_a), .sample_count(cnt_a), .overrun(ovr_a),
    .timeout_err(to_a), .sched_busy(sb_a)
  );

  node_scheduler #(
    .SAMPLE_PERIOD(10), .BATCH_SIZE(2), .ACCEPT_TIMEOUT(4)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .run(run_b), .ctrl_busy(busy_b),
    .radio_busy(rbusy_b), .rx_pending(rx_b), .ctrl_enable(en_b),
    .ctrl_inst(inst_b), .sample_count(cnt_b), .overrun(ovr_b),
    .timeout_err(to_b), .sched_busy(sb_b)
  );

  // Controller model for A: busy rises on the 2nd cycle an instruction is
  // seen and stays high for hold_cyc edges.
  int wait_cnt = 0;
  int busy_left = 0;
  int hold_cyc = 3;
  always @(negedge clk) begin
    if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) busy_a = 1'b0;
    end else if (inst_a != 2'b00) begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt == 2) begin
        busy_a    = 1'b1;
        busy_left = hold_cyc;
        wait_cnt  = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int ovr_tally, to_tally, ones_b;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; run_a = 1'b0; run_b = 1'b0; rx_a = 1'b0;
    step(); step();
    check_eq("rst_en_a",   32'(en_a),   0);
    check_eq("rst_inst_a", 32'(inst_a), 0);
    check_eq("rst_cnt_a",  32'(cnt_a),  0);
    check_eq("rst_ovr_a",  32'(ovr_a),  0);
    check_eq("rst_to_a",   32'(to_a),   0);
    check_eq("rst_sb_a",   32'(sb_a),   0);
    check_eq("rst_inst_b", 32'(inst_b), 0);

    rst_a = 1'b0; rst_b = 1'b0; run_a = 1'b1; run_b = 1'b1;
    ovr_tally = 0; to_tally = 0; ones_b = 0;
    for (int e = 0; e <= 60; e++) begin
      step();
      if (e <= 58 && ovr_a) ovr_tally++;
      if (to_a) to_tally++;
      if (e >= 9 && e <= 15 && inst_b == 2'b01) ones_b++;
      case (e)
        0:  begin check_eq("a_en@0", 32'(en_a), 1); check_eq("a_sb@0", 32'(sb_a), 0); end
        9:  begin check_eq("a_inst@9", 32'(inst_a), 0); check_eq("b_inst@9", 32'(inst_b), 0); end
        10: begin
              check_eq("a_inst@10", 32'(inst_a), 1); check_eq("a_sb@10", 32'(sb_a), 1);
              check_eq("b_inst@10", 32'(inst_b), 1);
            end
        12: begin
              check_eq("a_inst@12", 32'(inst_a), 0); check_eq("a_cnt@12", 32'(cnt_a), 1);
              check_eq("a_sb@12", 32'(sb_a), 1);
            end
        13: check_eq("b_inst@13", 32'(inst_b), 1);
        14: begin
              check_eq("b_inst@14", 32'(inst_b), 0); check_eq("b_to@14", 32'(to_b), 1);
              check_eq("b_cnt@14", 32'(cnt_b), 0);   check_eq("b_sb@14", 32'(sb_b), 0);
            end
        15: begin
              check_eq("a_sb@15", 32'(sb_a), 0); check_eq("b_to@15", 32'(to_b), 0);
              check_eq("b_inst01_cycles", 32'(ones_b), 4);
            end
        20: begin check_eq("a_inst@20", 32'(inst_a), 1); check_eq("b_inst@20", 32'(inst_b), 1); end
        22: begin
              check_eq("a_cnt@22", 32'(cnt_a), 2);
              check_eq("b_inst@22", 32'(inst_b), 0); check_eq("b_to@22", 32'(to_b), 0);
              check_eq("b_sb@22", 32'(sb_b), 0);
            end
        23: check_eq("b_en@23", 32'(en_b), 0);
        25: begin check_eq("b_inst@25", 32'(inst_b), 1); check_eq("b_en@25", 32'(en_b), 1); end
        26: check_eq("a_inst@26", 32'(inst_a), 3);
        28: begin check_eq("a_cnt@28", 32'(cnt_a), 0); check_eq("a_inst@28", 32'(inst_a), 0); end
        29: check_eq("b_to@29", 32'(to_b), 1);
        30: check_eq("b_inst@30", 32'(inst_b), 0);
        32: check_eq("a_inst@32", 32'(inst_a), 1);
        34: check_eq("b_inst@34", 32'(inst_b), 0);
        35: check_eq("b_inst@35", 32'(inst_b), 1);
        46: check_eq("a_inst@46", 32'(inst_a), 2);
        48: begin check_eq("a_inst@48", 32'(inst_a), 0); check_eq("a_cnt@48", 32'(cnt_a), 2); end
        51: check_eq("a_sb@51", 32'(sb_a), 0);
        52: check_eq("a_inst@52", 32'(inst_a), 3);
        54: check_eq("a_cnt@54", 32'(cnt_a), 0);
        58: check_eq("a_inst@58", 32'(inst_a), 1);
        59: check_eq("a_ovr@59", 32'(ovr_a), 1);
        60: begin
              check_eq("a_ovr@60", 32'(ovr_a), 0); check_eq("a_cnt@60", 32'(cnt_a), 1);
              check_eq("a_sb@60", 32'(sb_a), 1);
            end
        default: ;
      endcase
      if (e == 44) rx_a = 1'b1;
      if (e == 48) rx_a = 1'b0;
      if (e == 21) run_b = 1'b0;
      if (e == 24) run_b = 1'b1;
    end
    check_eq("a_ovr_tally_p1", 32'(ovr_tally), 0);
    check_eq("a_to_tally_p1",  32'(to_tally), 0);

    // Reset in the middle of a WAIT_DONE with one sample banked.
    hold_cyc = 25;
    rst_a = 1'b1;
    #1;
    check_eq("mid_rst_en",   32'(en_a),   0);
    check_eq("mid_rst_inst", 32'(inst_a), 0);
    check_eq("mid_rst_cnt",  32'(cnt_a),  0);
    check_eq("mid_rst_sb",   32'(sb_a),   0);
    check_eq("mid_rst_ovr",  32'(ovr_a),  0);
    check_eq("mid_rst_to",   32'(to_a),   0);
    step(); step();
    check_eq("held_rst_en", 32'(en_a), 0);
    rst_a = 1'b0;

    ovr_tally = 0;
    for (int r = 0; r <= 38; r++) begin
      step();
      if (ovr_a) ovr_tally++;
      case (r)
        0:  check_eq("r_sb@0", 32'(sb_a), 0);
        9:  check_eq("r_inst@9", 32'(inst_a), 0);
        10: check_eq("r_inst@10", 32'(inst_a), 1);
        12: check_eq("r_cnt@12", 32'(cnt_a), 1);
        29: check_eq("r_ovr@29", 32'(ovr_a), 1);
        36: check_eq("r_sb@36", 32'(sb_a), 1);
        37: begin check_eq("r_sb@37", 32'(sb_a), 0); check_eq("r_cnt@37", 32'(cnt_a), 1); end
        38: check_eq("r_inst@38", 32'(inst_a), 1);
        default: ;
      endcase
    end
    check_eq("r_ovr_tally", 32'(ovr_tally), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
